// File: rtl/sync_buffer_pkg.sv
// Shared types and constants for the sync buffer frame controller.
// State encoding, default minimum fval width and edge-detect latency.
package sync_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_END   = 2'd1,
    WAIT_START = 2'd2,
    ACTIVE     = 2'd3
  } state_t;

  localparam int DEF_MIN_FVAL_WIDTH = 3;
  localparam int EDGE_LAT = 2;

  function automatic int cnt_width(input int min_w);
    return $clog2(min_w + 1);
  endfunction

endpackage

// File: rtl/sync_buffer_fval_edge.sv
// Delay pipeline for fval/lval/data plus fval rise/fall detection.
// Ports: clk, rst, fval, lval, data in; fval_d1/d2, lval_d1, data_d1, rise, fall out.
module sync_buffer_fval_edge #(
  parameter int DW = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fval,
  input  logic          lval,
  input  logic [DW-1:0] data,
  output logic          fval_d1,
  output logic          fval_d2,
  output logic          lval_d1,
  output logic [DW-1:0] data_d1,
  output logic          rise,
  output logic          fall
);

  // fval taps reset high: a sensor already mid-frame at reset release
  // must look like an ongoing frame, never like a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fval_d1 <= 1'b1;
      fval_d2 <= 1'b1;
      lval_d1 <= 1'b0;
      data_d1 <= '0;
    end else begin
      fval_d1 <= fval;
      fval_d2 <= fval_d1;
      lval_d1 <= lval;
      data_d1 <= data;
    end
  end

  assign rise = fval_d1 & ~fval_d2;
  assign fall = ~fval_d1 & fval_d2;

endmodule

// File: rtl/sync_buffer_frame_ctrl.sv
// Frame-boundary gate in front of the sensor sync buffer: whole frames only,
// per-frame shadows of pixel_format/test_image_sel, short-fval flagging.
// Ports: clk_sensor_pix, reset_sensor, sensor fval/lval/data, acq/stream enables,
// live registers in; gated fval/lval/data, shadows, frame state, width error out.
// Option SYNC_BUFFER_FRAME_CNT_EN adds ov_frame_cnt (output frame counter).
module sync_buffer_frame_ctrl
  import sync_buffer_pkg::*;
#(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int CHANNEL_NUM      = 4,
  parameter int REG_WD           = 32,
  parameter int MIN_FVAL_WIDTH   = DEF_MIN_FVAL_WIDTH
) (
  input  logic                                  clk_sensor_pix,
  input  logic                                  reset_sensor,
  input  logic                                  i_fval,
  input  logic                                  i_lval,
  input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic                                  i_acquisition_start,
  input  logic                                  i_stream_enable,
  input  logic [REG_WD-1:0]                     iv_pixel_format,
  input  logic                                  i_test_image_sel,
  output logic                                  o_fval,
  output logic                                  o_lval,
  output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic [REG_WD-1:0]                     ov_pixel_format,
  output logic                                  o_test_image_sel,
  output logic                                  o_full_frame_state,
`ifdef SYNC_BUFFER_FRAME_CNT_EN
  output logic [15:0]                           ov_frame_cnt,
`endif
  output logic                                  o_fval_width_err
);

  localparam int DW = SENSOR_DAT_WIDTH * CHANNEL_NUM;
  localparam int CW = cnt_width(MIN_FVAL_WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(MIN_FVAL_WIDTH);

  logic          fval_d1;
  logic          fval_d2;
  logic          lval_d1;
  logic [DW-1:0] data_d1;
  logic          rise;
  logic          fall;

  sync_buffer_fval_edge #(.DW(DW)) u_edge (
    .clk     (clk_sensor_pix),
    .rst     (reset_sensor),
    .fval    (i_fval),
    .lval    (i_lval),
    .data    (iv_pix_data),
    .fval_d1 (fval_d1),
    .fval_d2 (fval_d2),
    .lval_d1 (lval_d1),
    .data_d1 (data_d1),
    .rise    (rise),
    .fall    (fall)
  );

  state_t        state;
  state_t        state_n;
  logic          enable;
  logic          start;
  logic          pass;
  logic          fval_nxt;
  logic [CW-1:0] cnt;

  assign enable = i_acquisition_start & i_stream_enable;

  // A frame starts only on a rise seen while armed and still enabled;
  // once started it runs to its fall regardless of enable.
  assign start = rise & enable &
                 ((state == WAIT_START) | (state == ACTIVE));
  assign pass  = start | ((state == ACTIVE) & fval_d2);
  assign fval_nxt = pass & fval_d1;

  always_ff @(posedge clk_sensor_pix or posedge reset_sensor) begin
    if (reset_sensor) state <= IDLE;
    else              state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (enable) state_n = fval_d1 ? WAIT_END : WAIT_START;
      end
      WAIT_END: begin
        if (!enable)   state_n = IDLE;
        else if (fall) state_n = WAIT_START;
      end
      WAIT_START: begin
        if (!enable)   state_n = IDLE;
        else if (rise) state_n = ACTIVE;
      end
      ACTIVE: begin
        // Leave only when not inside a running frame.
        if (!enable && !(fval_d1 && fval_d2)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sensor_pix or posedge reset_sensor) begin
    if (reset_sensor) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CW'(1);
    end else if (fval_d1 && cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_sensor_pix or posedge reset_sensor) begin
    if (reset_sensor) begin
      o_fval             <= 1'b0;
      o_lval             <= 1'b0;
      ov_pix_data        <= '0;
      o_full_frame_state <= 1'b0;
      ov_pixel_format    <= '0;
      o_test_image_sel   <= 1'b0;
      o_fval_width_err   <= 1'b0;
    end else begin
      o_fval             <= fval_nxt;
      o_lval             <= fval_nxt & lval_d1;
      ov_pix_data        <= fval_nxt ? data_d1 : '0;
      o_full_frame_state <= fval_nxt;
      o_fval_width_err   <= (state == ACTIVE) & fall &
                            (cnt < CNT_MAX);
      if (fval_nxt && !o_fval) begin
        ov_pixel_format  <= iv_pixel_format;
        o_test_image_sel <= i_test_image_sel;
      end
    end
  end

`ifdef SYNC_BUFFER_FRAME_CNT_EN
  always_ff @(posedge clk_sensor_pix or posedge reset_sensor) begin
    if (reset_sensor) begin
      ov_frame_cnt <= '0;
    end else if (state_n == IDLE && state != IDLE) begin
      ov_frame_cnt <= '0;
    end else if (fval_nxt && !o_fval) begin
      ov_frame_cnt <= ov_frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_buffer_frame_ctrl.sv
// Bench for sync_buffer_frame_ctrl: directed frame scenarios plus random
// traffic against a frame-level reference model.
module tb_sync_buffer_frame_ctrl;

  localparam int DW = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          fval;
  logic          lval;
  logic [DW-1:0] data;
  logic          acq;
  logic          sen;
  logic [31:0]   pf;
  logic          tis;
  logic          o_fval;
  logic          o_lval;
  logic [DW-1:0] o_data;
  logic [31:0]   o_pf;
  logic          o_tis;
  logic          o_ffs;
  logic          o_err;
`ifdef SYNC_BUFFER_FRAME_CNT_EN
  logic [15:0]   o_fcnt;
`endif

  always #5 clk = ~clk;

  sync_buffer_frame_ctrl dut (
    .clk_sensor_pix      (clk),
    .reset_sensor        (rst),
    .i_fval              (fval),
    .i_lval              (lval),
    .iv_pix_data         (data),
    .i_acquisition_start (acq),
    .i_stream_enable     (sen),
    .iv_pixel_format     (pf),
    .i_test_image_sel    (tis),
    .o_fval              (o_fval),
    .o_lval              (o_lval),
    .ov_pix_data         (o_data),
    .ov_pixel_format     (o_pf),
    .o_test_image_sel    (o_tis),
    .o_full_frame_state  (o_ffs),
`ifdef SYNC_BUFFER_FRAME_CNT_EN
    .ov_frame_cnt        (o_fcnt),
`endif
    .o_fval_width_err    (o_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: input history, whether the controller is armed to
  // accept the next frame start, and whether the current run is passed.
  logic          p, pp, lval_p;
  logic [DW-1:0] data_p;
  logic          armed, passing;
  int            run_len;
  logic          e_fval, e_lval, e_err;
  logic [DW-1:0] e_data;
  logic [31:0]   e_pf;
  logic          e_tis;
  int            fval_hi, err_cnt;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    // After reset the sensor state is unknown: assume mid-frame.
    p = 1'b1; pp = 1'b1; lval_p = 1'b0; data_p = '0;
    armed = 1'b0; passing = 1'b0; run_len = 0;
    e_pf = '0; e_tis = 1'b0;
  endtask

  task automatic check_all();
    chk("o_fval", 64'(o_fval), 64'(e_fval));
    chk("o_lval", 64'(o_lval), 64'(e_lval));
    chk("ov_pix_data", 64'(o_data), 64'(e_data));
    chk("o_full_frame_state", 64'(o_ffs), 64'(e_fval));
    chk("o_fval_width_err", 64'(o_err), 64'(e_err));
    chk("ov_pixel_format", 64'(o_pf), 64'(e_pf));
    chk("o_test_image_sel", 64'(o_tis), 64'(e_tis));
  endtask

  // Called at a negedge after inputs are set; advances one clock.
  task automatic cycle();
    logic en, rise_m, fall_m;
    en     = acq & sen;
    rise_m = p & ~pp;
    fall_m = ~p & pp;
    if (rise_m) begin
      passing = armed & en;
      run_len = 1;
      if (passing) begin
        e_pf  = pf;
        e_tis = tis;
      end
    end else if (p) begin
      run_len++;
    end
    e_err  = fall_m & passing & (run_len < 3);
    e_fval = passing & p;
    e_lval = e_fval & lval_p;
    e_data = e_fval ? data_p : '0;
    if (!p) passing = 1'b0;
    if (!en)     armed = 1'b0;
    else if (!p) armed = 1'b1;
    pp = p; p = fval; lval_p = lval; data_p = data;
    @(posedge clk);
    #1;
    check_all();
    if (o_fval) fval_hi++;
    if (o_err) err_cnt++;
    @(negedge clk);
  endtask

  task automatic drive(input logic f, input logic l);
    fval = f;
    lval = l;
    data = DW'({$urandom, $urandom});
    cycle();
  endtask

  task automatic frame(input int w, input int gap);
    for (int i = 0; i < w; i++) drive(1'b1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < gap; i++) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    rst = 1'b1; fval = 1'b0; lval = 1'b0; data = '0;
    acq = 1'b0; sen = 1'b0; pf = 32'h0108; tis = 1'b0;
    fval_hi = 0; err_cnt = 0;
    model_reset();
    e_fval = 1'b0; e_lval = 1'b0; e_data = '0; e_err = 1'b0;
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;
    model_reset();

    // Disabled: frame suppressed.
    frame(10, 5);

    // Enable with fval low, then a 100-clock frame.
    acq = 1'b1; sen = 1'b1;
    frame(1, 0);
    frame(0, 5);
    fval_hi = 0;
    frame(100, 8);
    chk("frame100_len", 64'(fval_hi), 64'd100);

    // Register change mid-frame stays hidden until the next frame.
    pf = 32'h0108; tis = 1'b0;
    frame(20, 0);
    pf = 32'h010C; tis = 1'b1;
    frame(20, 6);
    frame(15, 6);

    // Enable asserted mid-frame: that frame dropped, next passed.
    acq = 1'b0;
    frame(0, 4);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1);
    acq = 1'b1;
    frame(20, 5);
    fval_hi = 0;
    frame(20, 5);
    chk("after_mid_enable_len", 64'(fval_hi), 64'd20);

    // Enable dropped 10 clocks in: full frame, then suppressed.
    fval_hi = 0;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1);
    sen = 1'b0;
    frame(90, 6);
    frame(30, 6);
    chk("drop_enable_len", 64'(fval_hi), 64'd100);
    sen = 1'b1;
    frame(0, 4);

    // Short frames against MIN_FVAL_WIDTH=3.
    err_cnt = 0; fval_hi = 0;
    frame(1, 4);
    frame(2, 4);
    frame(3, 4);
    chk("short_err_pulses", 64'(err_cnt), 64'd2);
    chk("short_frames_len", 64'(fval_hi), 64'd6);

    // Reset mid-frame.
    frame(10, 0);
    rst = 1'b1;
    #1;
    chk("rst_o_fval", 64'(o_fval), 64'd0);
    chk("rst_o_lval", 64'(o_lval), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_pf", 64'(o_pf), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    fval_hi = 0;
    frame(20, 5);
    chk("post_reset_partial", 64'(fval_hi), 64'd0);
    frame(12, 5);
    chk("post_reset_next", 64'(fval_hi), 64'd12);

    // Random traffic with enable toggles and register changes.
    for (int k = 0; k < 120; k++) begin
      acq = ($urandom_range(0, 7) != 0);
      sen = ($urandom_range(0, 7) != 0);
      pf  = $urandom;
      tis = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        drive(1'b1, 1'($urandom_range(0, 1)));
      else
        drive(1'b0, 1'($urandom_range(0, 1)));
      frame($urandom_range(0, 6), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_buffer_frame_ctrl.md
Name: sync_buffer_frame_ctrl

Overview:
Frame-boundary controller in front of the sensor sync buffer, running in the sensor pixel domain. Applies acquisition start/stop and stream-enable so frames reach the sync buffer only whole. Freezes pixel_format and test_image selection per frame via shadow registers. Flags fval pulses shorter than the sync buffer's minimum supported width.

Parameters:
SENSOR_DAT_WIDTH, 10, bits per channel
CHANNEL_NUM, 4, pixel channels per clock
REG_WD, 32, register width for pixel_format
MIN_FVAL_WIDTH, 3, minimum legal fval high width in clocks

Ports:
clk_sensor_pix  input  1  pixel clock; single clock domain
reset_sensor  input  1  asynchronous, active-high reset
i_fval  input  1  sensor frame valid
i_lval  input  1  sensor line valid
iv_pix_data  input  SENSOR_DAT_WIDTH*CHANNEL_NUM  sensor pixel data
i_acquisition_start  input  1  level; acquisition requested
i_stream_enable  input  1  level; stream enabled
iv_pixel_format  input  REG_WD  live register value
i_test_image_sel  input  1  live register value
o_fval  output  1  gated frame valid to sync buffer
o_lval  output  1  gated line valid
ov_pix_data  output  SENSOR_DAT_WIDTH*CHANNEL_NUM  gated data; 0 when not gated through
ov_pixel_format  output  REG_WD  per-frame shadow
o_test_image_sel  output  1  per-frame shadow
o_full_frame_state  output  1  1 while a frame is being passed
o_fval_width_err  output  1  one-cycle pulse on short frame

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, width counter 0. Applies immediately, including mid-frame; after release the controller behaves as from power-up.
- enable = i_acquisition_start & i_stream_enable, sampled every cycle.
- Input pipeline: fval_d1, fval_d2, plus lval/data d1. rise = fval_d1 & ~fval_d2; fall = ~fval_d1 & fval_d2.
- Latency from i_fval/i_lval/iv_pix_data to o_fval/o_lval/ov_pix_data is fixed at 2 clocks. All outputs are registered.
- FSM:
  - IDLE: outputs gated. If enable and fval_d1, go to WAIT_END. If enable and not fval_d1, go to WAIT_START.
  - WAIT_END: the sensor is mid-frame, so discard the rest of it. On fall, go to WAIT_START. If enable=0, go to IDLE.
  - WAIT_START: on rise with enable=1, go to ACTIVE. If enable=0, go to IDLE.
  - ACTIVE: pass fval, lval and data. enable=0 mid-frame does not cut the frame. On fall, if enable=0, go to IDLE; otherwise stay in ACTIVE and take the next frame.
- Shadow registers: ov_pixel_format and o_test_image_sel load the live inputs in the cycle o_fval rises. They hold until the next o_fval rise, so they are constant for the whole output frame.
- Register writes during a frame are not visible until the next frame.
- o_full_frame_state equals o_fval.
- When gated: o_lval=0 and ov_pix_data=0. i_lval outside i_fval is passed but masked by fval (o_lval = lval & fval).
- Width check, ACTIVE only:
  - A saturating counter (width ceil(log2(MIN_FVAL_WIDTH+1))) counts fval_d1 high cycles and clears on rise.
  - On fall, if count < MIN_FVAL_WIDTH, pulse o_fval_width_err for 1 clock, aligned with o_fval falling.
  - The short frame is still passed.
- Simultaneous events:
  - rise and enable falling in the same cycle: frame not started.
  - fall and enable rising in the same cycle while in WAIT_END: go to WAIT_START, and the next rise is accepted.
  - fval high for 1 clock: valid rise and fall; counted as a short frame.

Optional Feature:
- SYNC_BUFFER_FRAME_CNT_EN defined: adds output ov_frame_cnt [15:0], reset 0.
  - Increments by 1, wrapping at 0xFFFF to 0, on every output frame rise.
  - Clears when entering IDLE.
- Not defined: no port and no counter logic.

Decomposition:
- Shared package sync_buffer_pkg holds:
  - FSM state encoding: IDLE=2'd0, WAIT_END=2'd1, WAIT_START=2'd2, ACTIVE=2'd3.
  - Default MIN_FVAL_WIDTH.
  - Edge-detect latency constant (2).
- One sub-module, sync_buffer_fval_edge: fval/lval/data delay pipeline plus rise/fall detect.
- FSM, shadows and width check stay in the top.

Test Plan:
- Enable asserted with fval low, then 100-clock frame → o_fval high exactly 100 clocks, 2 clocks after i_fval; data bit-exact with 2-cycle delay.
- Enable asserted mid-frame → that frame fully suppressed (o_fval=0); next frame passed whole.
- Enable deasserted 10 clocks into a 100-clock frame → full 100-clock o_fval, then IDLE; later frames suppressed.
- iv_pixel_format changed 0x0108→0x010C mid-frame → ov_pixel_format stays 0x0108 to frame end and becomes 0x010C at next o_fval rise; same check for i_test_image_sel.
- fval widths 1, 2, 3 with MIN_FVAL_WIDTH=3 → o_fval_width_err pulses for widths 1 and 2 only; all three frames passed.
- reset_sensor asserted mid-frame → outputs 0 in the same cycle; after release the controller re-enters via WAIT_END and no partial frame is emitted.
